// File: rtl/ascon_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between the ASCON-128a sequencer
// and its surroundings (wrapper on the block side, permutation/XOR/register
// datapath on the control side).
interface ascon_ctrl_fsm_if;
  logic       start_i;
  logic [3:0] nb_block_i;
  logic       block_valid_i;
  logic       block_ready_o;
  logic       enable_o;
  logic [3:0] round_o;
  logic       input_mode_o;
  logic       en_xor_begin_data_o;
  logic       en_xor_begin_key_o;
  logic       bypass_xor_end_o;
  logic       mode_xor_key_o;
  logic       en_reg_cipher_o;
  logic       en_reg_tag_o;
  logic       cipher_valid_o;
  logic [3:0] block_cnt_o;
  logic       busy_o;
  logic       done_o;

  // Wrapper / stimulus side: issues start and blocks, observes control.
  modport master (
    output start_i, nb_block_i, block_valid_i,
    input  block_ready_o, enable_o, round_o, input_mode_o,
           en_xor_begin_data_o, en_xor_begin_key_o, bypass_xor_end_o,
           mode_xor_key_o, en_reg_cipher_o, en_reg_tag_o, cipher_valid_o,
           block_cnt_o, busy_o, done_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, nb_block_i, block_valid_i,
    output block_ready_o, enable_o, round_o, input_mode_o,
           en_xor_begin_data_o, en_xor_begin_key_o, bypass_xor_end_o,
           mode_xor_key_o, en_reg_cipher_o, en_reg_tag_o, cipher_valid_o,
           block_cnt_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128a encryption sequencer: walks init (a rounds), one AD block
// (b rounds), N plaintext blocks and finalisation (a rounds), driving the
// round index, XOR stage controls and register enables as a Moore machine.
module ascon_ctrl_fsm #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 8
) (
  input logic           clock_i,
  input logic           resetb_i,
  ascon_ctrl_fsm_if.slave ctrl
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_WAIT_AD = 4'd2;
  localparam logic [3:0] S_AD      = 4'd3;
  localparam logic [3:0] S_WAIT_PT = 4'd4;
  localparam logic [3:0] S_PT      = 4'd5;
  localparam logic [3:0] S_FINAL   = 4'd6;
  localparam logic [3:0] S_TAG     = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  // Round constants are indexed so every phase ends on round 11.
  localparam logic [3:0] ROUND_LAST    = 4'd11;
  localparam logic [3:0] ROUND_A_FIRST = 4'(12 - ROUNDS_A);
  localparam logic [3:0] ROUND_B_FIRST = 4'(12 - ROUNDS_B);

  logic [3:0] state;
  logic [3:0] round;
  logic [3:0] block_cnt;
  logic [3:0] nb_last;
  logic       cipher_valid;
  logic       round_done;

  logic       block_ready;
  logic       enable;
  logic [3:0] round_out;
  logic       input_mode;
  logic       en_xor_begin_data;
  logic       en_xor_begin_key;
  logic       bypass_xor_end;
  logic       mode_xor_key;
  logic       en_reg_cipher;
  logic       en_reg_tag;
  logic       done;

  assign round_done = (round == ROUND_LAST);

  // Phase sequencing, round counter and plaintext block counter.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state     <= S_IDLE;
      round     <= 4'd0;
      block_cnt <= 4'd0;
      nb_last   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl.start_i) begin
            state     <= S_INIT;
            round     <= ROUND_A_FIRST;
            block_cnt <= 4'd0;
            nb_last   <= (ctrl.nb_block_i == 4'd0) ? 4'd0 : ctrl.nb_block_i - 4'd1;
          end
        end
        S_INIT: begin
          if (round_done) state <= S_WAIT_AD;
          else            round <= round + 4'd1;
        end
        S_WAIT_AD: begin
          if (ctrl.block_valid_i) begin
            state <= S_AD;
            round <= ROUND_B_FIRST;
          end
        end
        S_AD: begin
          if (round_done) begin
            state     <= S_WAIT_PT;
            block_cnt <= 4'd0;
          end else begin
            round <= round + 4'd1;
          end
        end
        S_WAIT_PT: begin
          if (ctrl.block_valid_i) begin
            if (block_cnt == nb_last) begin
              state <= S_FINAL;
              round <= ROUND_A_FIRST;
            end else begin
              state <= S_PT;
              round <= ROUND_B_FIRST;
            end
          end
        end
        S_PT: begin
          if (round_done) begin
            state <= S_WAIT_PT;
            if (block_cnt != 4'hF) block_cnt <= block_cnt + 4'd1;
          end else begin
            round <= round + 4'd1;
          end
        end
        S_FINAL: begin
          if (round_done) state <= S_TAG;
          else            round <= round + 4'd1;
        end
        S_TAG:   state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Cipher-valid trails the cipher register load by one cycle.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) cipher_valid <= 1'b0;
    else           cipher_valid <= en_reg_cipher;
  end

  // Datapath controls decoded from phase and round index.
  always_comb begin
    block_ready       = 1'b0;
    enable            = 1'b0;
    round_out         = 4'd0;
    input_mode        = 1'b0;
    en_xor_begin_data = 1'b0;
    en_xor_begin_key  = 1'b0;
    bypass_xor_end    = 1'b1;
    mode_xor_key      = 1'b0;
    en_reg_cipher     = 1'b0;
    en_reg_tag        = 1'b0;
    done              = 1'b0;
    case (state)
      S_INIT: begin
        enable     = 1'b1;
        round_out  = round;
        input_mode = (round != ROUND_A_FIRST);
        if (round_done) begin
          bypass_xor_end = 1'b0;
          mode_xor_key   = 1'b1;
        end
      end
      S_AD: begin
        enable     = 1'b1;
        round_out  = round;
        input_mode = 1'b1;
        if (round == ROUND_B_FIRST) begin
          en_xor_begin_data = 1'b1;
          block_ready       = 1'b1;
        end
        if (round_done) bypass_xor_end = 1'b0;
      end
      S_PT: begin
        enable     = 1'b1;
        round_out  = round;
        input_mode = 1'b1;
        if (round == ROUND_B_FIRST) begin
          en_xor_begin_data = 1'b1;
          en_reg_cipher     = 1'b1;
          block_ready       = 1'b1;
        end
      end
      S_FINAL: begin
        enable     = 1'b1;
        round_out  = round;
        input_mode = 1'b1;
        if (round == ROUND_A_FIRST) begin
          en_xor_begin_data = 1'b1;
          en_xor_begin_key  = 1'b1;
          en_reg_cipher     = 1'b1;
          block_ready       = 1'b1;
        end
        if (round_done) begin
          bypass_xor_end = 1'b0;
          mode_xor_key   = 1'b1;
        end
      end
      S_TAG:   en_reg_tag = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign ctrl.block_ready_o       = block_ready;
  assign ctrl.enable_o            = enable;
  assign ctrl.round_o             = round_out;
  assign ctrl.input_mode_o        = input_mode;
  assign ctrl.en_xor_begin_data_o = en_xor_begin_data;
  assign ctrl.en_xor_begin_key_o  = en_xor_begin_key;
  assign ctrl.bypass_xor_end_o    = bypass_xor_end;
  assign ctrl.mode_xor_key_o      = mode_xor_key;
  assign ctrl.en_reg_cipher_o     = en_reg_cipher;
  assign ctrl.en_reg_tag_o        = en_reg_tag;
  assign ctrl.cipher_valid_o      = cipher_valid;
  assign ctrl.block_cnt_o         = block_cnt;
  assign ctrl.busy_o              = (state != S_IDLE);
  assign ctrl.done_o              = done;

endmodule
